// File: rtl/uart_writer_arbiter.sv
// Round-robin arbiter sharing one uart_writer between several debugger sources.
// Optional watchdog abort on a stuck writer: define UART_WRITER_ARBITER_TIMEOUT_EN.
module uart_writer_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned IN_BUS_SIZE    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic [NUM_REQUESTERS-1:0]             i_req,
  input  logic [NUM_REQUESTERS*IN_BUS_SIZE-1:0] i_req_data,
  input  logic                                  i_wr_end,
  output logic                                  o_start_wr,
  output logic [IN_BUS_SIZE-1:0]                o_wr_data,
  output logic [NUM_REQUESTERS-1:0]             o_grant,
  output logic [NUM_REQUESTERS-1:0]             o_ack,
  output logic                                  o_busy,
  output logic                                  o_timeout
);

  localparam int unsigned PW = $clog2(NUM_REQUESTERS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_END,
    DONE
  } state_t;

  state_t                    state;
  logic [PW-1:0]             ptr;
  logic [PW-1:0]             pick_idx;
  logic                      pick_valid;
  logic [IN_BUS_SIZE-1:0]    pick_data;
  logic [NUM_REQUESTERS-1:0] pick_onehot;
  logic                      wr_end_q;
  logic                      end_edge;
  int unsigned               cand;

`ifdef UART_WRITER_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] to_cnt;
`endif

  // Search starts just past the last owner, so the previous winner ranks last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = (32'(ptr) + k) % NUM_REQUESTERS;
      if (!pick_valid && i_req[PW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  assign pick_data   = i_req_data[pick_idx*IN_BUS_SIZE +: IN_BUS_SIZE];
  assign pick_onehot = NUM_REQUESTERS'(1) << pick_idx;

  // The writer's end flag is sticky; only a fresh rising edge marks completion.
  assign end_edge = i_wr_end && !wr_end_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      ptr        <= PW'(NUM_REQUESTERS - 1);
      wr_end_q   <= 1'b0;
      o_start_wr <= 1'b0;
      o_wr_data  <= '0;
      o_grant    <= '0;
      o_ack      <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
`ifdef UART_WRITER_ARBITER_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      wr_end_q   <= i_wr_end;
      o_start_wr <= 1'b0;
      o_ack      <= '0;
      o_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            o_grant    <= pick_onehot;
            o_wr_data  <= pick_data;
            ptr        <= pick_idx;
            o_start_wr <= 1'b1;
            o_busy     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          state <= WAIT_END;
`ifdef UART_WRITER_ARBITER_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        WAIT_END: begin
          if (end_edge) begin
            o_ack <= o_grant;
            state <= DONE;
          end
`ifdef UART_WRITER_ARBITER_TIMEOUT_EN
          else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            o_timeout <= 1'b1;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_writer_arbiter.sv
// Scoreboard bench for uart_writer_arbiter with a behavioural uart_writer end-flag model.
module tb_uart_writer_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           wr_end;
  logic           start_wr;
  logic [W-1:0]   wr_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           busy;
  logic           timeout;

  always #5 clk = ~clk;

  uart_writer_arbiter #(
    .NUM_REQUESTERS(N),
    .IN_BUS_SIZE(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_req(req),
    .i_req_data(req_data),
    .i_wr_end(wr_end),
    .o_start_wr(start_wr),
    .o_wr_data(wr_data),
    .o_grant(grant),
    .o_ack(ack),
    .o_busy(busy),
    .o_timeout(timeout)
  );

  typedef struct {
    logic [N-1:0] grant;
    logic [W-1:0] data;
  } xfer_t;

  xfer_t sb[$];
  xfer_t inflight[$];
  xfer_t mon_e;
  int    checks = 0;
  int    failures = 0;
  int    left[N];
  int    cyc = 0;
  int    last_ack_cyc = -100;
  int    rise_cyc = -100;
  logic  prev_end = 1'b0;
  bit    check_gap = 1'b0;
  bit    have_ack = 1'b0;
  int    end_delay = 10;
  int    stale_hold = 0;
  bit    hang = 1'b0;
  int    m_phase = 0;
  int    m_cnt = 0;

  // Writer model: samples start, drops the end flag after stale_hold cycles, raises it later.
  initial begin : writer_model
    wr_end = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        wr_end  = 1'b0;
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (m_cnt >= stale_hold) begin
          wr_end  = 1'b0;
          m_phase = 2;
          m_cnt   = 0;
        end else m_cnt++;
      end else if (m_phase == 2) begin
        m_cnt++;
        if (m_cnt >= end_delay && !hang) begin
          wr_end  = 1'b1;
          m_phase = 0;
        end
      end
      if (rst_n && start_wr) begin
        m_phase = 1;
        m_cnt   = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (wr_end && !prev_end) rise_cyc = cyc;
      prev_end = wr_end;
      if (start_wr) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_start grant=%b wr_data=%h", grant, wr_data);
        end else begin
          mon_e = sb.pop_front();
          if (grant !== mon_e.grant || wr_data !== mon_e.data) begin
            failures++;
            $display("FAIL start_word grant=%b data=%h expected grant=%b data=%h",
                     grant, wr_data, mon_e.grant, mon_e.data);
          end
          inflight.push_back(mon_e);
        end
        if (check_gap && have_ack) begin
          checks++;
          if (cyc - last_ack_cyc != 2) begin
            failures++;
            $display("FAIL idle_gap cycles=%0d expected=2", cyc - last_ack_cyc);
          end
        end
      end
      if (ack != '0) begin
        checks++;
        if (inflight.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack ack=%b", ack);
        end else begin
          mon_e = inflight.pop_front();
          if (ack !== mon_e.grant || wr_data !== mon_e.data || rise_cyc != cyc) begin
            failures++;
            $display("FAIL ack ack=%b data=%h rise_lag=%0d expected ack=%b data=%h rise_lag=0",
                     ack, wr_data, cyc - rise_cyc, mon_e.grant, mon_e.data);
          end
        end
        have_ack     = 1'b1;
        last_ack_cyc = cyc;
        for (int k = 0; k < N; k++) begin
          if (ack[k]) begin
            left[k]--;
            if (left[k] <= 0) req[k] = 1'b0;
          end
        end
      end
      if (timeout && inflight.size() > 0) mon_e = inflight.pop_front();
    end
  end

  task automatic set_word(input int ch, input logic [W-1:0] d);
    req_data[ch*W +: W] = d;
  endtask

  task automatic request(input int ch, input int n, input logic [W-1:0] d);
    set_word(ch, d);
    left[ch] = n;
    req[ch]  = 1'b1;
  endtask

  task automatic push_exp(input int ch, input logic [W-1:0] d);
    xfer_t e;
    e.grant     = '0;
    e.grant[ch] = 1'b1;
    e.data      = d;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    inflight.delete();
    have_ack = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((sb.size() != 0 || inflight.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d inflight=%0d busy=%b", name, sb.size(), inflight.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    checks++; if (start_wr !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start_wr); end
    checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", wr_data); end
    checks++; if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=0", grant); end
    checks++; if (ack !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    request(1, 1, 32'hDEADBEEF);
    push_exp(1, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010 || start_wr !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_latency grant=%b start=%b busy=%b exp 0010 1 1", grant, start_wr, busy);
    end
    checks++;
    if (wr_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_data got=%h exp=deadbeef", wr_data);
    end
    @(negedge clk);
    checks++;
    if (start_wr !== 1'b0 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL single_pulse start=%b grant=%b exp 0 0010", start_wr, grant);
    end
    wait_done(40, "single");
    checks++;
    if (busy !== 1'b0 || grant !== '0 || ack !== '0) begin
      failures++;
      $display("FAIL single_idle busy=%b grant=%b ack=%b exp 0", busy, grant, ack);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int k = 0; k < N; k++) set_word(k, 32'hC0DE0000 + k);
    left[0] = 2; left[1] = 1; left[2] = 1; left[3] = 1;
    push_exp(0, 32'hC0DE0000);
    push_exp(1, 32'hC0DE0001);
    push_exp(2, 32'hC0DE0002);
    push_exp(3, 32'hC0DE0003);
    push_exp(0, 32'hC0DE0000);
    check_gap = 1'b1;
    req = 4'b1111;
    wait_done(200, "fairness");
    check_gap = 1'b0;
  endtask

  task automatic test_late_arrival();
    int n = 0;
    have_ack  = 1'b0;
    check_gap = 1'b1;
    request(0, 1, 32'hA0A00000);
    push_exp(0, 32'hA0A00000);
    repeat (3) @(negedge clk);
    request(2, 1, 32'h11112222);
    repeat (2) @(negedge clk);
    set_word(2, 32'h22223333);
    push_exp(2, 32'h22223333);
    while (grant !== 4'b0100 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (grant !== 4'b0100 || wr_data !== 32'h22223333) begin
      failures++;
      $display("FAIL late_grant grant=%b data=%h exp 0100 22223333", grant, wr_data);
    end
    set_word(2, 32'hBAD0BAD0);
    wait_done(60, "late");
    check_gap = 1'b0;
  endtask

  task automatic test_stale_end();
    int n = 0;
    stale_hold = 3;
    request(3, 1, 32'h5A5A0003);
    push_exp(3, 32'h5A5A0003);
    while (start_wr !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== '0) begin
        failures++;
        $display("FAIL stale_ack cycle=%0d ack=%b exp=0000", i, ack);
      end
    end
    wait_done(60, "stale");
    stale_hold = 0;
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    request(1, 1, 32'h0BADF00D);
    push_exp(1, 32'h0BADF00D);
    repeat (4) @(negedge clk);
    hang  = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== '0 || start_wr !== 1'b0 || wr_data !== '0 ||
        ack !== '0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs grant=%b start=%b data=%h ack=%b busy=%b to=%b exp all 0",
               grant, start_wr, wr_data, ack, busy, timeout);
    end
    rst_n = 1'b1;
    req   = '0;
    sb.delete();
    inflight.delete();
    have_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midreset_quiet ack=%b busy=%b exp 0", ack, busy);
    end
    hang = 1'b0;
    request(1, 1, 32'h11110001);
    request(3, 1, 32'h33330003);
    push_exp(1, 32'h11110001);
    push_exp(3, 32'h33330003);
    wait_done(80, "midreset");
  endtask

`ifdef UART_WRITER_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    hang = 1'b1;
    request(0, 1, 32'h70700000);
    request(2, 1, 32'h70700002);
    push_exp(0, 32'h70700000);
    push_exp(2, 32'h70700002);
    while (start_wr !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TO + 1 || ack !== '0 || grant !== '0) begin
      failures++;
      $display("FAIL timeout_pulse delay=%0d ack=%b grant=%b exp delay=%0d ack=0 grant=0",
               n, ack, grant, TO + 1);
    end
    req[0] = 1'b0;
    hang   = 1'b0;
    wait_done(80, "timeout");
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    for (int k = 0; k < N; k++) left[k] = 0;
    test_reset();
    test_single();
    test_fairness();
    test_late_arrival();
    test_stale_end();
    test_reset_mid();
`ifdef UART_WRITER_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
